// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the CPU data-memory port. A request is accepted
// from IDLE when mem_clk is high and exactly one of rd/wr is high. The address,
// write data and direction are latched at that point. The block then waits a
// programmable number of cycles and performs the access on an internal
// synchronous RAM. The result is presented with a ready handshake and, for
// reads, a drive enable for the shared data bus.
//
// Ports
//   clk       in   single system clock
//   reset     in   synchronous, active-high reset
//   mem_clk   in   CPU memory-phase enable; sampled as data, never a clock
//   addr      in   ADDR_W  data address from the CPU data MAR
//   rd        in   read strobe
//   wr        in   write strobe
//   wdata     in   DATA_W  write data taken from the data bus
//   par_flip  in   (DMEM_PARITY_EN only) inverts the stored parity of a write
//   rdata     out  DATA_W  registered read data
//   rdata_oe  out  read-data bus drive enable
//   ready     out  access complete; held until the latched strobe drops
//   err       out  sticky error flag (protocol errors, plus parity errors
//                  when DMEM_PARITY_EN is defined); cleared only by reset
//
// Build option
//   DMEM_PARITY_EN : stores one even-parity bit per word and checks it on
//                    reads. When it is not defined there is no parity storage
//                    and no par_flip port.
//
// Latency: a request sampled at edge N raises ready at edge N+1+WAIT_STATES.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_PARITY_EN
  input  logic              par_flip,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              ready,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef DMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;   // parity bit sits above the data bits
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q, ready_d;
  logic                oe_q, oe_d;
  logic                err_q, err_d;

  logic                resp_entry;
  logic                strobe_held;
  logic [MEM_W-1:0]    rd_word;
  logic [MEM_W-1:0]    wr_word;
  logic                par_err;

  logic [MEM_W-1:0]    mem_q [DEPTH];

  // Only the strobe that started the access keeps it alive; a direction flip
  // therefore reads as a deassertion.
  assign strobe_held = is_wr_q ? wr : rd;

  assign rd_word = mem_q[addr_q];

`ifdef DMEM_PARITY_EN
  assign wr_word = {(^wdata_q) ^ par_flip, wdata_q};
  assign par_err = resp_entry && !is_wr_q &&
                   (rd_word[DATA_W] != (^rd_word[DATA_W-1:0]));
`else
  assign wr_word = wdata_q;
  assign par_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = ready_q;
    oe_d       = oe_q;
    err_d      = err_q;
    resp_entry = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_clk) begin
          if (rd && wr) begin
            err_d = 1'b1;
          end else if (rd || wr) begin
            is_wr_d = wr;
            addr_d  = addr;
            wdata_d = wdata;
            // The counter runs WAIT_STATES+1 WAIT cycles so the response
            // edge lands at N+1+WAIT_STATES, including WAIT_STATES=0.
            wcnt_d  = WS_CNT;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!strobe_held) begin
          // Aborted: nothing written, nothing driven.
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d    = S_RESP;
          resp_entry = 1'b1;
          ready_d    = 1'b1;
          oe_d       = !is_wr_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      S_RESP: begin
        if (!strobe_held) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          oe_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        oe_d    = 1'b0;
      end
    endcase

    if (par_err) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
      if (resp_entry && !is_wr_q) begin
        rdata_q <= rd_word[DATA_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array (not cleared by reset). A write lands on the RESP-entry edge;
  // reset on that same edge cancels it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && resp_entry && is_wr_q) begin
      mem_q[addr_q] <= wr_word;
    end
  end

  assign rdata    = rdata_q;
  assign rdata_oe = oe_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Three instances run side by side with
// WAIT_STATES = 1 (index 0), 0 (index 1) and 3 (index 2), each with its own
// stimulus signals. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        rst [3];
  logic        mc  [3];
  logic        rd  [3];
  logic        wr  [3];
  logic [7:0]  ad  [3];
  logic [15:0] wd  [3];
  logic        pf  [3];
  logic [15:0] rdv [3];
  logic        oe  [3];
  logic        rdy [3];
  logic        er  [3];

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(rst[0]), .mem_clk(mc[0]), .addr(ad[0]), .rd(rd[0]),
    .wr(wr[0]), .wdata(wd[0]),
`ifdef DMEM_PARITY_EN
    .par_flip(pf[0]),
`endif
    .rdata(rdv[0]), .rdata_oe(oe[0]), .ready(rdy[0]), .err(er[0])
  );

  data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst[1]), .mem_clk(mc[1]), .addr(ad[1]), .rd(rd[1]),
    .wr(wr[1]), .wdata(wd[1]),
`ifdef DMEM_PARITY_EN
    .par_flip(pf[1]),
`endif
    .rdata(rdv[1]), .rdata_oe(oe[1]), .ready(rdy[1]), .err(er[1])
  );

  data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst[2]), .mem_clk(mc[2]), .addr(ad[2]), .rd(rd[2]),
    .wr(wr[2]), .wdata(wd[2]),
`ifdef DMEM_PARITY_EN
    .par_flip(pf[2]),
`endif
    .rdata(rdv[2]), .rdata_oe(oe[2]), .ready(rdy[2]), .err(er[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs driven
  // 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One complete access: request, wait for ready, hold one cycle, release.
  task automatic access(input int k, input bit w, input logic [7:0] a,
                        input logic [15:0] d, input int exp_lat,
                        input logic [15:0] exp_rd);
    int n;
    mc[k] = 1'b1; rd[k] = !w; wr[k] = w; ad[k] = a; wd[k] = d;
    tick();                       // edge N: request accepted
    ad[k] = ~a; wd[k] = ~d;       // must be ignored from here on
    n = 0;
    do begin
      tick();
      n++;
    end while (!rdy[k] && n < 20);
    $display("txn inst=%0d %s addr=%02h wdata=%04h latency=%0d rdata=%04h oe=%0b",
             k, w ? "WR" : "RD", a, d, n, rdv[k], oe[k]);
    check($sformatf("lat_i%0d_a%02h", k, a), n, exp_lat);
    if (!w) begin
      check($sformatf("rdata_i%0d_a%02h", k, a), rdv[k], exp_rd);
      check($sformatf("oe_rd_i%0d", k), oe[k], 1);
    end else begin
      check($sformatf("oe_wr_i%0d", k), oe[k], 0);
    end
    tick();                       // strobe still high: response held
    check($sformatf("hold_rdy_i%0d", k), rdy[k], 1);
    rd[k] = 1'b0; wr[k] = 1'b0; mc[k] = 1'b0;
    tick();                       // strobe seen low: back to IDLE
    check($sformatf("drop_rdy_i%0d", k), rdy[k], 0);
    check($sformatf("drop_oe_i%0d", k), oe[k], 0);
    if (!w) check($sformatf("rdata_hold_i%0d", k), rdv[k], exp_rd);
  endtask

  initial begin
    bit seen;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; mc[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
      ad[k] = 8'h00; wd[k] = 16'h0000; pf[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdata_i%0d", k), rdv[k], 0);
      check($sformatf("rst_oe_i%0d", k), oe[k], 0);
      check($sformatf("rst_rdy_i%0d", k), rdy[k], 0);
      check($sformatf("rst_err_i%0d", k), er[k], 0);
      rst[k] = 1'b0;
    end
    tick();

    // WAIT_STATES=1: write then read back, ready at N+2.
    access(0, 1'b1, 8'h12, 16'hBEEF, 2, 16'h0000);
    access(0, 1'b0, 8'h12, 16'h0000, 2, 16'hBEEF);

    // WAIT_STATES=0: ready one edge after acceptance.
    access(1, 1'b1, 8'h00, 16'h1234, 1, 16'h0000);
    access(1, 1'b0, 8'h00, 16'h0000, 1, 16'h1234);
    check("err_clean_i1", er[1], 0);

    // mem_clk low: strobe ignored.
    rd[1] = 1'b1; ad[1] = 8'h00; mc[1] = 1'b0;
    repeat (3) tick();
    check("mclk0_rdy", rdy[1], 0);
    rd[1] = 1'b0;
    tick();

    // Both strobes: err set, no access.
    mc[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 8'h12; wd[0] = 16'h5555;
    tick();
    check("both_err", er[0], 1);
    check("both_rdy", rdy[0], 0);
    tick();
    check("both_rdy2", rdy[0], 0);
    check("both_oe", oe[0], 0);
    mc[0] = 1'b0; rd[0] = 1'b0; wr[0] = 1'b0;
    tick();
    access(0, 1'b0, 8'h12, 16'h0000, 2, 16'hBEEF);
    check("err_sticky", er[0], 1);

    // WAIT_STATES=3: write aborted in WAIT leaves old data.
    access(2, 1'b1, 8'h40, 16'h0000, 4, 16'h0000);
    mc[2] = 1'b1; wr[2] = 1'b1; ad[2] = 8'h40; wd[2] = 16'h7777;
    tick();                       // accepted
    tick();                       // one WAIT cycle
    wr[2] = 1'b0; mc[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= rdy[2];
    end
    check("abort_no_rdy", seen, 0);
    access(2, 1'b0, 8'h40, 16'h0000, 4, 16'h0000);

    // Reset during WAIT discards an in-flight write.
    access(2, 1'b1, 8'h05, 16'h0505, 4, 16'h0000);
    access(2, 1'b0, 8'h05, 16'h0000, 4, 16'h0505);
    mc[2] = 1'b1; wr[2] = 1'b1; ad[2] = 8'h05; wd[2] = 16'hAAAA;
    tick();                       // accepted
    tick();                       // in WAIT
    rst[2] = 1'b1;
    tick();
    check("wrst_rdata", rdv[2], 0);
    check("wrst_oe", oe[2], 0);
    check("wrst_rdy", rdy[2], 0);
    check("wrst_err", er[2], 0);
    rst[2] = 1'b0; wr[2] = 1'b0; mc[2] = 1'b0;
    tick();
    access(2, 1'b0, 8'h05, 16'h0000, 4, 16'h0505);

`ifdef DMEM_PARITY_EN
    // Corrupted parity: data still returned, err raised.
    pf[1] = 1'b1;
    access(1, 1'b1, 8'h33, 16'h0001, 1, 16'h0000);
    pf[1] = 1'b0;
    check("par_err_after_wr", er[1], 0);
    access(1, 1'b0, 8'h33, 16'h0000, 1, 16'h0001);
    check("par_err", er[1], 1);
`else
    check("err_final_i1", er[1], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
